// File: rtl/serpar_receiver_pkg.sv
// rtl/serpar_receiver_pkg.sv - shared constants and output FSM state type for the serial-to-parallel receiver
package serpar_receiver_pkg;

    localparam int DEFAULT_M = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/serpar_receiver_if.sv
// rtl/serpar_receiver_if.sv - serial input / parallel output bundle for the receiver
interface serpar_receiver_if
    import serpar_receiver_pkg::*;
#(
    parameter int M = DEFAULT_M
);

    logic         bit_in;
    logic         shift;
    logic         sync;
    logic         out_ready;
    logic         clr_ovr;
    logic [M-1:0] bus_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    // Producer / consumer side: drives serial bits and handshakes, observes the word.
    modport master (
        output bit_in, shift, sync, out_ready, clr_ovr,
        input  bus_out, out_valid, busy, overrun
    );

    // Receiver side.
    modport slave (
        input  bit_in, shift, sync, out_ready, clr_ovr,
        output bus_out, out_valid, busy, overrun
    );

endinterface

// File: rtl/serpar_receiver.sv
// rtl/serpar_receiver.sv - LSB-first serial-to-parallel receiver with one-word output holding register
module serpar_receiver
    import serpar_receiver_pkg::*;
#(
    parameter int M = DEFAULT_M
) (
    input  logic         clk,
    input  logic         reset,
    serpar_receiver_if.slave bus
);

    localparam int CW = $clog2(M);
    localparam logic [CW-1:0] LAST_BIT = CW'(M - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  sr_q, sr_d;
    logic [M-1:0]  bus_out_q, bus_out_d;
    out_state_e    state_q, state_d;
    logic          ovr_q, ovr_d;

    logic          accept;
    logic          complete;
    logic          ovr_set;
    logic [M-1:0]  shifted;

    // Bit acceptance: sync takes priority and swallows any bit offered alongside it.
    always_comb begin
        accept   = bus.shift & ~bus.sync;
        shifted  = {bus.bit_in, sr_q[M-1:1]};
        complete = accept && (cnt_q == LAST_BIT);
    end

    // Shift register and bit counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (bus.sync) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (complete) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            sr_d  = shifted;
        end
    end

    // Output FSM: holding register load, consumption and overrun detection.
    always_comb begin
        state_d   = state_q;
        bus_out_d = bus_out_q;
        ovr_set   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    bus_out_d = shifted;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    bus_out_d = shifted;
                    ovr_set   = ~bus.out_ready;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A fresh loss outranks a clear arriving in the same cycle.
        ovr_d = ovr_set | (ovr_q & ~bus.clr_ovr);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            bus_out_q <= '0;
            state_q   <= EMPTY;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            bus_out_q <= bus_out_d;
            state_q   <= state_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.bus_out   = bus_out_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.busy      = (cnt_q != '0);
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_serpar_receiver.sv
// tb/tb_serpar_receiver.sv - self-checking bench for serpar_receiver with a word-level reference model
module tb_serpar_receiver;
    import serpar_receiver_pkg::*;

    localparam int M = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Reference model: partial word assembled by bit position, plus output holding state.
    int           m_cnt;
    logic [M-1:0] m_word;
    logic [M-1:0] m_bus;
    logic         m_valid;
    logic         m_ovr;

    serpar_receiver_if #(.M(M)) bus_if ();

    serpar_receiver #(.M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt   = 0;
        m_word  = '0;
        m_bus   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_update(input logic sh, input logic b, input logic sy,
                                input logic rd, input logic cl);
        logic lost;
        lost = 1'b0;
        if (sy) begin
            m_cnt  = 0;
            m_word = '0;
            if (rd && m_valid) m_valid = 1'b0;
        end else if (sh) begin
            m_word[m_cnt] = b;
            m_cnt = m_cnt + 1;
            if (m_cnt == M) begin
                if (m_valid && !rd) lost = 1'b1;
                m_bus   = m_word;
                m_valid = 1'b1;
                m_cnt   = 0;
                m_word  = '0;
            end else if (rd && m_valid) begin
                m_valid = 1'b0;
            end
        end else if (rd && m_valid) begin
            m_valid = 1'b0;
        end
        if (lost) m_ovr = 1'b1;
        else if (cl) m_ovr = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, land 1 time unit past the edge.
    task automatic step(input logic sh, input logic b, input logic sy,
                        input logic rd, input logic cl);
        bus_if.shift     = sh;
        bus_if.bit_in    = b;
        bus_if.sync      = sy;
        bus_if.out_ready = rd;
        bus_if.clr_ovr   = cl;
        @(posedge clk);
        model_update(sh, b, sy, rd, cl);
        #1;
    endtask

    task automatic send_word(input logic [M-1:0] w, input logic rd_last);
        for (int i = 0; i < M; i++) begin
            step(1'b1, w[i], 1'b0, (i == M - 1) ? rd_last : 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_if.shift = 1'b0; bus_if.bit_in = 1'b0; bus_if.sync = 1'b0;
        bus_if.out_ready = 1'b0; bus_if.clr_ovr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.bus_out !== '0) begin failures++; $display("FAIL reset_bus_out got=%h exp=00", bus_if.bus_out); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus_if.overrun); end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_a5();
        logic [M-1:0] bits;
        bits = 8'hA5;
        for (int i = 0; i < M - 1; i++) step(1'b1, bits[i], 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL a5_valid_early got=%b exp=0", bus_if.out_valid); end
        step(1'b1, bits[M-1], 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.bus_out !== 8'hA5) begin failures++; $display("FAIL a5_bus_out got=%h exp=a5", bus_if.bus_out); end
        checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL a5_out_valid got=%b exp=1", bus_if.out_valid); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL a5_busy got=%b exp=0", bus_if.busy); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL a5_consume got=%b exp=0", bus_if.out_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b0 || bus_if.bus_out !== 8'hA5) begin
            failures++; $display("FAIL ready_while_empty valid=%b bus=%h exp valid=0 bus=a5", bus_if.out_valid, bus_if.bus_out);
        end
    endtask

    task automatic test_gapped_3c();
        logic [M-1:0] w;
        int busy_bad;
        w = 8'h3C;
        busy_bad = 0;
        for (int i = 0; i < M; i++) begin
            step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
            if (i < M - 1) begin
                if (bus_if.busy !== 1'b1) busy_bad++;
                repeat ($urandom_range(3, 1)) begin
                    step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
                    if (bus_if.busy !== 1'b1) busy_bad++;
                end
            end
        end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL gap_busy low_samples=%0d exp=0", busy_bad); end
        checks++; if (bus_if.bus_out !== 8'h3C) begin failures++; $display("FAIL gap_bus_out got=%h exp=3c", bus_if.bus_out); end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b1 || bus_if.bus_out !== 8'h3C) begin
            failures++; $display("FAIL gap_hold valid=%b bus=%h exp valid=1 bus=3c", bus_if.out_valid, bus_if.bus_out);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        checks++; if (bus_if.bus_out !== 8'h22) begin failures++; $display("FAIL ovr_bus_out got=%h exp=22", bus_if.bus_out); end
        checks++; if (bus_if.overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus_if.overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus_if.overrun); end
        checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_kept got=%b exp=1", bus_if.out_valid); end
        // Set wins over clear in the same cycle.
        for (int i = 0; i < M - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (bus_if.overrun !== 1'b1 || bus_if.bus_out !== 8'hFF) begin
            failures++; $display("FAIL ovr_set_wins ovr=%b bus=%h exp ovr=1 bus=ff", bus_if.overrun, bus_if.bus_out);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_simul_ready();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        checks++; if (bus_if.bus_out !== 8'h22) begin failures++; $display("FAIL simul_bus_out got=%h exp=22", bus_if.bus_out); end
        checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL simul_valid got=%b exp=1", bus_if.out_valid); end
        checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL simul_overrun got=%b exp=0", bus_if.overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sync();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL sync_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL sync_valid got=%b exp=0", bus_if.out_valid); end
        send_word(8'hF0, 1'b0);
        checks++; if (bus_if.bus_out !== 8'hF0) begin failures++; $display("FAIL sync_bus_out got=%h exp=f0", bus_if.bus_out); end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (bus_if.bus_out !== '0 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.overrun !== 1'b0) begin
            failures++; $display("FAIL async_reset bus=%h valid=%b busy=%b ovr=%b exp all 0",
                                 bus_if.bus_out, bus_if.out_valid, bus_if.busy, bus_if.overrun);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_word(8'h81, 1'b0);
        checks++; if (bus_if.bus_out !== 8'h81 || bus_if.out_valid !== 1'b1) begin
            failures++; $display("FAIL post_reset_81 bus=%h valid=%b exp bus=81 valid=1", bus_if.bus_out, bus_if.out_valid);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(1, 0)), 1'($urandom),
                 ($urandom_range(15, 0) == 0), ($urandom_range(2, 0) == 0),
                 ($urandom_range(7, 0) == 0));
            checks++;
            if (bus_if.bus_out !== m_bus || bus_if.out_valid !== m_valid ||
                bus_if.overrun !== m_ovr || bus_if.busy !== (m_cnt != 0)) begin
                failures++;
                if (bad < 10) $display("FAIL random cyc=%0d bus=%h/%h valid=%b/%b ovr=%b/%b busy=%b/%b (got/exp)",
                                       n, bus_if.bus_out, m_bus, bus_if.out_valid, m_valid,
                                       bus_if.overrun, m_ovr, bus_if.busy, (m_cnt != 0));
                bad++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_a5();
        test_gapped_3c();
        test_overrun();
        test_simul_ready();
        test_sync();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serpar_receiver.md
SERPAR_RECEIVER -- requirements
Module: serpar_receiver

Interface
REQ-001 Parameter M, default 8, meaning word width in bits (M >= 2).
REQ-002 The block SHALL have one clock and reset SHALL be asynchronous and active-low: clk input 1 rising-edge clock; reset input 1 asynchronous active-low reset.
REQ-003 bit_in input 1, serial data bit, sampled only when shift=1.
REQ-004 shift input 1, bit strobe: one serial bit accepted per cycle with shift=1.
REQ-005 sync input 1, resynchronise: discards the partial word and restarts at bit 0.
REQ-006 out_ready input 1, consumer accepts bus_out when out_valid=1.
REQ-007 clr_ovr input 1, clears the sticky overrun flag.
REQ-008 bus_out output M, last completed word, first received bit in bus_out[0].
REQ-009 out_valid output 1, bus_out holds an unconsumed word.
REQ-010 busy output 1, high while a partial word is held (bit counter != 0).
REQ-011 overrun output 1, sticky: a completed word was lost.

Function
REQ-012 Serial order SHALL be LSB first; each accepted bit enters the MSB of a shift register that shifts right.
REQ-013 A bit counter SHALL count 0..M-1 and advance only on accepted shift cycles.
REQ-014 On the edge accepting bit M-1: counter wraps to 0; the full word (including this bit) is written to bus_out; out_valid=1 from the next cycle, giving 1-cycle latency after the last bit.
REQ-015 Output FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 EMPTY->FULL on word completion; FULL->EMPTY on out_ready=1 with no completion in the same cycle.
REQ-017 Completion and out_ready in the same FULL cycle: new word loaded, FSM stays FULL, overrun not set.
REQ-018 Completion in FULL without out_ready: new word overwrites bus_out, FSM stays FULL, overrun set to 1.
REQ-019 bus_out SHALL be stable while FULL unless REQ-017 or REQ-018 applies.
REQ-020 sync=1 SHALL clear the counter and shift register; a bit presented with shift=1 in the same cycle is discarded; out_valid, bus_out and overrun are unaffected.
REQ-021 clr_ovr=1 clears overrun; if an overrun event occurs in the same cycle, overrun stays 1 (set wins).
REQ-022 shift=0 cycles SHALL hold all state; there is no timeout.
REQ-023 out_ready while EMPTY SHALL have no effect.

Reset
REQ-024 While reset=0 (asynchronous): bus_out=0, out_valid=0, busy=0, overrun=0, counter=0, shift register=0, FSM=EMPTY.
REQ-025 Reset asserted mid-word SHALL discard the partial word; the first accepted bit after release is bit 0.
REQ-026 Reset release SHALL take effect at the first rising clk edge with reset=1.

Structure
REQ-027 A shared package SHALL hold the default word-width constant (8) and the output FSM state typedef (EMPTY, FULL).
REQ-028 Counter width SHALL be $clog2(M) bits, taken from the parameter rather than hard-coded.
REQ-029 No sub-module is needed; the shift register, counter and FSM are implemented in this module.

Verification
REQ-030 M=8, shift=1 for 8 consecutive cycles with bits 1,0,1,0,0,1,0,1 -> bus_out=0xA5, out_valid=1 one cycle after the 8th bit, busy=0.
REQ-031 Send 0x3C with shift gapped by idle cycles, out_ready=0 -> bus_out=0x3C, out_valid held, busy=1 during bits 1..7.
REQ-032 Send 0x11 then 0x22 with out_ready=0 -> bus_out=0x22, overrun=1; then clr_ovr pulse -> overrun=0, out_valid=1.
REQ-033 FULL with 0x11; complete 0x22 in the same cycle as out_ready=1 -> bus_out=0x22, out_valid=1, overrun=0.
REQ-034 Send 3 bits, then sync=1, then send 0xF0 -> bus_out=0xF0; the 3 partial bits do not appear.
REQ-035 Assert reset after 5 bits of a word -> all outputs 0 immediately; after release, sending 0x81 -> bus_out=0x81.
